// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage issue sequencer.
package ex_pkg;
  localparam int EX_OP_W   = 6;
  localparam int EX_DATA_W = 32;
  localparam int EX_RD_W   = 5;

  // Bit positions inside wb_flags = {err, con_met, zero, overflow}
  localparam int WB_FLAG_OVF  = 0;
  localparam int WB_FLAG_ZERO = 1;
  localparam int WB_FLAG_CON  = 2;
  localparam int WB_FLAG_ERR  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_FLUSH,
    ST_HOLD
  } ex_seq_state_t;
endpackage

// File: rtl/ex_seq_counter.sv
// Loadable down-counter; done while the count sits at zero.
module ex_seq_counter #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  // Load wins over decrement; count saturates at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (load_i)              cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/ex_issue_sequencer.sv
// EX-stage issue sequencer: holds operands for the ALU, waits for its
// ready (with a watchdog flush), and presents the result to writeback.
module ex_issue_sequencer
  import ex_pkg::*;
#(
  parameter int DAT_READY_CYCLES = 3,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                 soc_clk,
  input  logic                 EX_reset_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [EX_DATA_W-1:0] issue_rs1,
  input  logic [EX_DATA_W-1:0] issue_rs2,
  input  logic [EX_DATA_W-1:0] issue_imm,
  input  logic [EX_OP_W-1:0]   issue_op,
  input  logic                 issue_use_imm,
  input  logic [EX_RD_W-1:0]   issue_rd,
  output logic [EX_DATA_W-1:0] alu_dat1,
  output logic [EX_DATA_W-1:0] alu_dat2,
  output logic [EX_OP_W-1:0]   alu_op,
  output logic                 alu_dat_ready,
  output logic                 alu_clear,
  input  logic                 alu_ready,
  input  logic                 alu_overflow,
  input  logic                 alu_zero,
  input  logic                 alu_con_met,
  input  logic                 alu_err,
  input  logic [EX_DATA_W-1:0] alu_out,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [EX_DATA_W-1:0] wb_data,
  output logic [EX_RD_W-1:0]   wb_rd,
  output logic [3:0]           wb_flags,
  output logic                 wb_timeout,
  output logic                 busy
);
  localparam int CNT_MAX = (DAT_READY_CYCLES > TIMEOUT_CYCLES) ? DAT_READY_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DR_LOAD = CNT_W'(DAT_READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       FLUSH_FLAGS = 4'(1 << WB_FLAG_ERR);

  ex_seq_state_t        state_q;
  logic [EX_DATA_W-1:0] dat1_q, dat2_q, wb_data_q;
  logic [EX_OP_W-1:0]   op_q;
  logic [EX_RD_W-1:0]   rd_q, wb_rd_q;
  logic [3:0]           wb_flags_q;
  logic                 dat_rdy_q, flush_q, wb_valid_q, wb_to_q;

  logic             accept, capture, cnt_done, cnt_load, cnt_en;
  logic [CNT_W-1:0] cnt_load_val;

  assign accept  = issue_valid && (state_q == ST_IDLE);
  assign capture = alu_ready && (state_q == ST_DRIVE || state_q == ST_WAIT);

  // One counter serves both phases: reload for the DRIVE window on accept,
  // and for the watchdog when the window expires without an early ready.
  assign cnt_load     = accept || (state_q == ST_DRIVE && cnt_done && !alu_ready);
  assign cnt_load_val = accept ? DR_LOAD : TO_LOAD;
  assign cnt_en       = (state_q == ST_DRIVE) || (state_q == ST_WAIT);

  ex_seq_counter #(.W(CNT_W)) u_cnt (
    .clk_i      (soc_clk),
    .rst_ni     (EX_reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .done_o     (cnt_done)
  );

  // Sequencer FSM with its registered operand, result and control outputs.
  always_ff @(posedge soc_clk or negedge EX_reset_n) begin
    if (!EX_reset_n) begin
      state_q    <= ST_IDLE;
      dat1_q     <= '0;
      dat2_q     <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      dat_rdy_q  <= 1'b0;
      flush_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_flags_q <= '0;
      wb_to_q    <= 1'b0;
    end else begin
      if (capture) begin
        wb_data_q  <= alu_out;
        wb_flags_q <= {alu_err, alu_con_met, alu_zero, alu_overflow};
        wb_rd_q    <= rd_q;
        wb_to_q    <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (issue_valid) begin
          dat1_q    <= issue_rs1;
          dat2_q    <= issue_use_imm ? issue_imm : issue_rs2;
          op_q      <= issue_op;
          rd_q      <= issue_rd;
          dat_rdy_q <= 1'b1;
          state_q   <= ST_DRIVE;
        end
        ST_DRIVE: if (alu_ready) begin
          dat_rdy_q  <= 1'b0;
          wb_valid_q <= 1'b1;
          state_q    <= ST_HOLD;
        end else if (cnt_done) begin
          dat_rdy_q <= 1'b0;
          state_q   <= ST_WAIT;
        end
        // Ready in the last watchdog cycle still counts as a normal result.
        ST_WAIT: if (alu_ready) begin
          wb_valid_q <= 1'b1;
          state_q    <= ST_HOLD;
        end else if (cnt_done) begin
          flush_q <= 1'b1;
          state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          flush_q    <= 1'b0;
          wb_valid_q <= 1'b1;
          wb_data_q  <= '0;
          wb_flags_q <= FLUSH_FLAGS;
          wb_rd_q    <= rd_q;
          wb_to_q    <= 1'b1;
          state_q    <= ST_HOLD;
        end
        ST_HOLD: if (wb_ready) begin
          wb_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign issue_ready   = EX_reset_n && (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign alu_clear     = !EX_reset_n || flush_q;
  assign alu_dat_ready = dat_rdy_q;
  assign alu_dat1      = dat1_q;
  assign alu_dat2      = dat2_q;
  assign alu_op        = op_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_flags      = wb_flags_q;
  assign wb_timeout    = wb_to_q;
endmodule

// File: tb/tb_ex_issue_sequencer.sv
// Self-checking bench for ex_issue_sequencer with a cycle-level ALU model.
module tb_ex_issue_sequencer;
  localparam int D = 3;
  localparam int T = 16;

  logic        soc_clk = 1'b0, EX_reset_n = 1'b0;
  logic        issue_valid = 1'b0, issue_ready, issue_use_imm = 1'b0;
  logic [31:0] issue_rs1 = '0, issue_rs2 = '0, issue_imm = '0;
  logic [5:0]  issue_op = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] alu_dat1, alu_dat2, alu_out = '0, wb_data;
  logic [5:0]  alu_op;
  logic        alu_dat_ready, alu_clear, alu_ready = 1'b0;
  logic        alu_overflow = 1'b0, alu_zero = 1'b0, alu_con_met = 1'b0, alu_err = 1'b0;
  logic        wb_valid, wb_ready = 1'b0, wb_timeout, busy;
  logic [4:0]  wb_rd;
  logic [3:0]  wb_flags;

  int n_checks = 0, n_fail = 0;

  ex_issue_sequencer #(.DAT_READY_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .soc_clk(soc_clk), .EX_reset_n(EX_reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm),
    .issue_op(issue_op), .issue_use_imm(issue_use_imm), .issue_rd(issue_rd),
    .alu_dat1(alu_dat1), .alu_dat2(alu_dat2), .alu_op(alu_op),
    .alu_dat_ready(alu_dat_ready), .alu_clear(alu_clear), .alu_ready(alu_ready),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_con_met(alu_con_met),
    .alu_err(alu_err), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_flags(wb_flags), .wb_timeout(wb_timeout), .busy(busy)
  );

  always #5 soc_clk = ~soc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in ALU arithmetic; the bench only needs a value tied to the operands.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    return (a + b) ^ {26'd0, op};
  endfunction

  // Observations from one transaction (t=1 is the cycle right after accept).
  int          obs_wait, obs_dr, obs_clr, obs_clr_t, obs_t_wb;
  logic        obs_busy1, obs_to, obs_stable, obs_ir_hold, obs_post_valid, obs_post_ir;
  logic [31:0] obs_dat1, obs_dat2, obs_data;
  logic [5:0]  obs_op;
  logic [4:0]  obs_rd;
  logic [3:0]  obs_flags;

  // Drives one issue, plays the ALU (ready pulse at t==lat, lat=0 never),
  // holds off writeback for 'hold' cycles, then completes the handshake.
  task automatic do_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [5:0] op, input logic ui, input logic [4:0] rd,
                       input int lat, input int hold, input bit spur, input logic [3:0] fl);
    logic [31:0] fr;
    int t;
    bit seen;
    fr = alu_fn(rs1, ui ? imm : rs2, op);
    obs_wait = 0; obs_dr = 0; obs_clr = 0; obs_clr_t = -1; obs_t_wb = -1;
    while (!issue_ready && obs_wait < 50) begin @(posedge soc_clk); #1; obs_wait++; end
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm;
    issue_op = op; issue_use_imm = ui; issue_rd = rd;
    @(posedge soc_clk); #1;
    issue_valid = 1'b0; issue_rs1 = $urandom; issue_rs2 = $urandom; issue_imm = $urandom;
    issue_op = 6'($urandom); issue_use_imm = ~ui; issue_rd = 5'($urandom);
    obs_busy1 = busy; obs_dat1 = alu_dat1; obs_dat2 = alu_dat2; obs_op = alu_op;
    t = 1; seen = 0;
    while (!seen && t <= D + T + 8) begin
      if (wb_valid) begin
        seen = 1; obs_t_wb = t;
      end else begin
        if (alu_dat_ready) obs_dr++;
        if (alu_clear) begin obs_clr++; obs_clr_t = t; end
        alu_ready = (t == lat);
        alu_out = (t == lat) ? fr : $urandom;
        {alu_err, alu_con_met, alu_zero, alu_overflow} = (t == lat) ? fl : 4'($urandom);
        @(posedge soc_clk); #1; t++;
      end
    end
    alu_ready = 1'b0;
    obs_data = wb_data; obs_flags = wb_flags; obs_rd = wb_rd; obs_to = wb_timeout;
    obs_stable = 1'b1; obs_ir_hold = 1'b0;
    for (int h = 0; h < hold; h++) begin
      alu_ready = spur; alu_out = ~fr;
      @(posedge soc_clk); #1;
      if (wb_valid !== 1'b1 || wb_data !== obs_data || wb_flags !== obs_flags ||
          wb_rd !== obs_rd || wb_timeout !== obs_to) obs_stable = 1'b0;
      if (issue_ready !== 1'b0) obs_ir_hold = 1'b1;
    end
    alu_ready = 1'b0;
    wb_ready = 1'b1;
    @(posedge soc_clk); #1;
    wb_ready = 1'b0;
    obs_post_valid = wb_valid; obs_post_ir = issue_ready;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
    n_checks++; if (alu_clear !== 1'b1) begin n_fail++; $display("FAIL rst_alu_clear: got %b want 1", alu_clear); end
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || alu_dat_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got v=%b b=%b dr=%b want 0", wb_valid, busy, alu_dat_ready); end
    n_checks++; if (wb_data !== 32'd0 || alu_dat1 !== 32'd0 || wb_flags !== 4'd0) begin n_fail++; $display("FAIL rst_data: got %h %h %h want 0", wb_data, alu_dat1, wb_flags); end
    repeat (2) @(posedge soc_clk);
    #1 EX_reset_n = 1'b1;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_issue_ready: got %b want 1", issue_ready); end
    n_checks++; if (alu_clear !== 1'b0) begin n_fail++; $display("FAIL post_rst_alu_clear: got %b want 0", alu_clear); end
  endtask

  task automatic test_imm_basic();
    do_op(32'd5, 32'hDEAD_BEEF, 32'd7, 6'h0A, 1'b1, 5'd3, 4, 1, 1'b0, 4'b0010);
    n_checks++; if (obs_busy1 !== 1'b1) begin n_fail++; $display("FAIL imm_accept: got busy=%b want 1", obs_busy1); end
    n_checks++; if (obs_dat1 !== 32'd5 || obs_op !== 6'h0A) begin n_fail++; $display("FAIL imm_dat1_op: got %h %h want 5 0a", obs_dat1, obs_op); end
    n_checks++; if (obs_dat2 !== 32'd7) begin n_fail++; $display("FAIL imm_dat2: got %h want 7", obs_dat2); end
    n_checks++; if (obs_dr !== D) begin n_fail++; $display("FAIL imm_dat_ready_len: got %0d want %0d", obs_dr, D); end
    n_checks++; if (obs_t_wb !== 5) begin n_fail++; $display("FAIL imm_wb_latency: got %0d want 5", obs_t_wb); end
    n_checks++; if (obs_data !== alu_fn(32'd5, 32'd7, 6'h0A)) begin n_fail++; $display("FAIL imm_wb_data: got %h want %h", obs_data, alu_fn(32'd5, 32'd7, 6'h0A)); end
    n_checks++; if (obs_to !== 1'b0 || obs_flags !== 4'b0010 || obs_rd !== 5'd3) begin n_fail++; $display("FAIL imm_wb_meta: got to=%b fl=%b rd=%0d want 0 0010 3", obs_to, obs_flags, obs_rd); end
  endtask

  task automatic test_timeout();
    do_op(32'h11, 32'h22, 32'h33, 6'h01, 1'b0, 5'd9, 0, 0, 1'b0, 4'b0000);
    n_checks++; if (obs_clr !== 1 || obs_clr_t !== D + T + 1) begin n_fail++; $display("FAIL to_clear_pulse: got n=%0d t=%0d want 1 %0d", obs_clr, obs_clr_t, D + T + 1); end
    n_checks++; if (obs_t_wb !== D + T + 2) begin n_fail++; $display("FAIL to_wb_latency: got %0d want %0d", obs_t_wb, D + T + 2); end
    n_checks++; if (obs_data !== 32'd0 || obs_flags !== 4'b1000 || obs_to !== 1'b1) begin n_fail++; $display("FAIL to_result: got %h %b %b want 0 1000 1", obs_data, obs_flags, obs_to); end
    n_checks++; if (obs_dr !== D || obs_rd !== 5'd9) begin n_fail++; $display("FAIL to_dr_rd: got %0d %0d want %0d 9", obs_dr, obs_rd, D); end
  endtask

  task automatic test_backpressure();
    do_op(32'h100, 32'h200, 32'h300, 6'h05, 1'b0, 5'd17, 2, 5, 1'b1, 4'b0101);
    n_checks++; if (obs_dat2 !== 32'h200) begin n_fail++; $display("FAIL bp_dat2_rs2: got %h want 200", obs_dat2); end
    n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold_stable: got %b want 1", obs_stable); end
    n_checks++; if (obs_ir_hold !== 1'b0) begin n_fail++; $display("FAIL bp_issue_ready_hold: got %b want 0", obs_ir_hold); end
    n_checks++; if (obs_data !== alu_fn(32'h100, 32'h200, 6'h05) || obs_t_wb !== 3) begin n_fail++; $display("FAIL bp_result: got %h t=%0d want %h 3", obs_data, obs_t_wb, alu_fn(32'h100, 32'h200, 6'h05)); end
    n_checks++; if (obs_post_valid !== 1'b0 || obs_post_ir !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs: got v=%b ir=%b want 0 1", obs_post_valid, obs_post_ir); end
    do_op(32'h7, 32'h8, 32'h9, 6'h02, 1'b1, 5'd4, 3, 0, 1'b0, 4'b0001);
    n_checks++; if (obs_wait !== 0 || obs_busy1 !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got wait=%0d busy=%b want 0 1", obs_wait, obs_busy1); end
  endtask

  task automatic test_coincident();
    do_op(32'hABCD, 32'h1234, 32'h0, 6'h3F, 1'b0, 5'd21, D + T, 0, 1'b0, 4'b0110);
    n_checks++; if (obs_t_wb !== D + T + 1 || obs_clr !== 0) begin n_fail++; $display("FAIL coin_latency: got t=%0d clr=%0d want %0d 0", obs_t_wb, obs_clr, D + T + 1); end
    n_checks++; if (obs_to !== 1'b0 || obs_flags !== 4'b0110) begin n_fail++; $display("FAIL coin_flags: got to=%b fl=%b want 0 0110", obs_to, obs_flags); end
    n_checks++; if (obs_data !== alu_fn(32'hABCD, 32'h1234, 6'h3F)) begin n_fail++; $display("FAIL coin_data: got %h want %h", obs_data, alu_fn(32'hABCD, 32'h1234, 6'h3F)); end
  endtask

  task automatic test_reset_midop();
    int w;
    w = 0;
    while (!issue_ready && w < 50) begin @(posedge soc_clk); #1; w++; end
    issue_valid = 1'b1; issue_rs1 = 32'h55; issue_rs2 = 32'h66; issue_use_imm = 1'b0; issue_rd = 5'd8;
    @(posedge soc_clk); #1;
    issue_valid = 1'b0;
    repeat (D + 1) begin @(posedge soc_clk); #1; end
    n_checks++; if (busy !== 1'b1 || alu_dat_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_wait: got busy=%b dr=%b want 1 0", busy, alu_dat_ready); end
    #2 EX_reset_n = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got v=%b busy=%b want 0 0", wb_valid, busy); end
    n_checks++; if (alu_clear !== 1'b1 || issue_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got clr=%b ir=%b want 1 0", alu_clear, issue_ready); end
    @(posedge soc_clk); #1;
    n_checks++; if (alu_clear !== 1'b1 || alu_dat_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_clear_held: got clr=%b dr=%b want 1 0", alu_clear, alu_dat_ready); end
    EX_reset_n = 1'b1;
    #1;
    n_checks++; if (alu_clear !== 1'b0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release: got clr=%b ir=%b want 0 1", alu_clear, issue_ready); end
    do_op(32'h1, 32'h2, 32'h3, 6'h04, 1'b1, 5'd30, 6, 1, 1'b0, 4'b0011);
    n_checks++; if (obs_data !== alu_fn(32'h1, 32'h3, 6'h04) || obs_to !== 1'b0 || obs_rd !== 5'd30) begin n_fail++; $display("FAIL rmid_next_op: got %h to=%b rd=%0d want %h 0 30", obs_data, obs_to, obs_rd, alu_fn(32'h1, 32'h3, 6'h04)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'h1000 * (k + 1);
      do_op(a, a + 1, 32'h0, 6'(k), 1'b0, 5'(10 + k), 1 + k, 0, 1'b0, 4'(k));
      n_checks++; if (obs_rd !== 5'(10 + k) || obs_data !== alu_fn(a, a + 1, 6'(k))) begin n_fail++; $display("FAIL b2b_result%0d: got rd=%0d %h want %0d %h", k, obs_rd, obs_data, 10 + k, alu_fn(a, a + 1, 6'(k))); end
      n_checks++; if (obs_t_wb !== k + 2 || obs_wait !== 0) begin n_fail++; $display("FAIL b2b_timing%0d: got t=%0d wait=%0d want %0d 0", k, obs_t_wb, obs_wait, k + 2); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rs1, rs2, imm, ef;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [3:0]  fl, efl;
    logic        ui, eto;
    int          lat, hold, etwb, edr;
    for (int k = 0; k < 24; k++) begin
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; op = 6'($urandom); rd = 5'($urandom);
      ui = 1'($urandom); fl = 4'($urandom); hold = $urandom_range(0, 3);
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, D + T + 3);
      eto  = (lat == 0) || (lat > D + T);
      etwb = eto ? D + T + 2 : lat + 1;
      edr  = (eto || lat > D) ? D : lat;
      ef   = eto ? 32'd0 : alu_fn(rs1, ui ? imm : rs2, op);
      efl  = eto ? 4'b1000 : fl;
      do_op(rs1, rs2, imm, op, ui, rd, lat, hold, 1'($urandom), fl);
      n_checks++; if (obs_dat2 !== (ui ? imm : rs2)) begin n_fail++; $display("FAIL rnd_dat2[%0d]: got %h want %h", k, obs_dat2, ui ? imm : rs2); end
      n_checks++; if (obs_t_wb !== etwb || obs_dr !== edr || obs_wait !== 0) begin n_fail++; $display("FAIL rnd_timing[%0d]: got t=%0d dr=%0d w=%0d want %0d %0d 0", k, obs_t_wb, obs_dr, obs_wait, etwb, edr); end
      n_checks++; if (obs_data !== ef || obs_flags !== efl || obs_to !== eto || obs_rd !== rd) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h %b %b %0d want %h %b %b %0d", k, obs_data, obs_flags, obs_to, obs_rd, ef, efl, eto, rd); end
      n_checks++; if (obs_stable !== 1'b1 || obs_post_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_hold[%0d]: got stable=%b post_v=%b want 1 0", k, obs_stable, obs_post_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_imm_basic();
    test_timeout();
    test_backpressure();
    test_coincident();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
